// File: rtl/bch_pkg.sv
// Shared types and helpers for the BCH encoder family: FSM state,
// standard generator polynomials and the single-step parity LFSR update.
package bch_pkg;

  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } state_e;

  // Widest parity register the step helper supports.
  localparam int MAX_R = 32;

  localparam logic [8:0]  BCH_15_7_POLY = 9'b111010001;
  localparam logic [10:0] BCH_15_5_POLY = 11'b10100110111;

  // One division step: shift the remainder left and fold in the generator
  // when the incoming bit differs from the outgoing top bit.
  function automatic logic [MAX_R-1:0] lfsr_step(
    input logic [MAX_R-1:0] par,
    input logic             msg_bit,
    input logic [MAX_R-1:0] poly,
    input int               r
  );
    logic             fb;
    logic [MAX_R-1:0] mask;
    logic [MAX_R-1:0] nxt;
    fb   = msg_bit ^ par[r-1];
    mask = (MAX_R'(1) << r) - MAX_R'(1);
    nxt  = (par << 1) ^ (fb ? poly : '0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/bch_encode_par_if.sv
// Stream bundle between the framer, the BCH encoder and the modulator FIFO.
interface bch_encode_par_if #(
  parameter int WIDTH = 1
);
  // Handshake: a beat transfers on the rising edge where valid && ready;
  // valid never waits on ready, and a source holding valid keeps data stable.
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eof
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/bch_lfsr_step.sv
// Combinational WIDTH-step parity update, MSB of data_i applied first.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int         R        = 8,
  parameter int         WIDTH    = 1,
  parameter logic [R:0] GEN_POLY = BCH_15_7_POLY
) (
  input  logic [R-1:0]     par_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [R-1:0]     par_o
);

  logic [MAX_R-1:0] acc;
  logic             unused_hi;

  always_comb begin
    acc = MAX_R'(par_i);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc = lfsr_step(acc, data_i[i], MAX_R'(GEN_POLY[R-1:0]), R);
    end
    par_o     = acc[R-1:0];
    unused_hi = ^acc[MAX_R-1:R];
  end

endmodule

// File: rtl/bch_encode_par.sv
// Parallel systematic BCH encoder: passes K message bits through, then
// emits the N-K parity bits, WIDTH bits per beat with sof/eof framing.
module bch_encode_par
  import bch_pkg::*;
#(
  parameter int             N        = 15,
  parameter int             K        = 7,
  parameter int             WIDTH    = 1,
  parameter logic [N-K:0]   GEN_POLY = BCH_15_7_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  bch_encode_par_if.slave   bus,
  output state_e            dbg_state_o
);

  localparam int R    = N - K;
  localparam int DB   = K / WIDTH;
  localparam int PB   = R / WIDTH;
  localparam int MAXB = (DB > PB) ? DB : PB;
  localparam int CW   = $clog2(MAXB + 1);

  if (((K % WIDTH) != 0) || ((R % WIDTH) != 0)) begin : g_width_check
    $error("bch_encode_par: WIDTH must divide both K and N-K");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [R-1:0]     par_q;
  logic [R-1:0]     par_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_sof_q;
  logic             out_eof_q;
  logic             adv;
  logic             in_ready;

  bch_lfsr_step #(
    .R        (R),
    .WIDTH    (WIDTH),
    .GEN_POLY (GEN_POLY)
  ) u_step (
    .par_i  (par_q),
    .data_i (bus.in_data),
    .par_o  (par_d)
  );

  // The single output stage may take a new beat when empty or being drained.
  assign adv      = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == MSG) && adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MSG;
      cnt_q       <= '0;
      par_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (adv) begin
      case (state_q)
        MSG: begin
          if (bus.in_valid) begin
            out_data_q  <= bus.in_data;
            out_valid_q <= 1'b1;
            out_sof_q   <= (cnt_q == '0);
            out_eof_q   <= 1'b0;
            par_q       <= par_d;
            if (cnt_q == CW'(DB - 1)) begin
              cnt_q   <= '0;
              state_q <= PAR;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
          end
        end
        PAR: begin
          out_data_q  <= par_q[R-1 -: WIDTH];
          out_valid_q <= 1'b1;
          out_sof_q   <= 1'b0;
          if (cnt_q == CW'(PB - 1)) begin
            // Clearing here lets the next frame start from a zero remainder.
            out_eof_q <= 1'b1;
            par_q     <= '0;
            cnt_q     <= '0;
            state_q   <= MSG;
          end else begin
            out_eof_q <= 1'b0;
            par_q     <= par_q << WIDTH;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        default: state_q <= MSG;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bch_encode_par.sv
// Directed and randomised checks of bch_encode_par: a bit-serial BCH(15,7)
// instance with a codeword scoreboard, plus a 5-bit-wide BCH(15,5) instance.
module tb_bch_encode_par;
  import bch_pkg::*;

  localparam int W = 3;  // {sof, eof, data} for the bit-serial instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch_encode_par_if #(.WIDTH(1)) bus_a ();
  bch_encode_par_if #(.WIDTH(5)) bus_b ();
  state_e st_a;
  state_e st_b;

  bch_encode_par #(
    .N(15), .K(7), .WIDTH(1), .GEN_POLY(BCH_15_7_POLY)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state_o(st_a)
  );

  bch_encode_par #(
    .N(15), .K(5), .WIDTH(5), .GEN_POLY(BCH_15_5_POLY)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state_o(st_b)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_sof_cyc = 0;
  int last_eof_cyc = 0;
  bit rand_ready = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: remainder of m(x)*x^8 by long division.
  function automatic logic [7:0] ref_par(input logic [6:0] msg);
    logic [14:0] rem;
    rem = {msg, 8'b0};
    for (int i = 14; i >= 8; i--) begin
      if (rem[i]) rem = rem ^ (15'(BCH_15_7_POLY) << (i - 8));
    end
    return rem[7:0];
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    bus_a.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_a.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  bit           stalled = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    cyc++;
    got = {bus_a.out_sof, bus_a.out_eof, bus_a.out_data};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(bus_a.out_valid), 32'd1);
        chk("stall_hold", 32'(got), 32'(held));
      end
      stalled = 1'b0;
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL extra_beat: observed %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          chk("beat", 32'(got), 32'(exp));
          if (bus_a.out_sof) last_sof_cyc = cyc;
          if (bus_a.out_eof) last_eof_cyc = cyc;
        end
      end else if (bus_a.out_valid) begin
        stalled = 1'b1;
        held    = got;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [6:0] msg, input logic [7:0] par);
    logic [14:0] cw;
    cw = {msg, par};
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back({(i == 0), (i == 14), cw[14-i]});
    end
  endtask

  task automatic drive_beat_a(input logic b, input bit gaps);
    bit acc;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      bus_a.in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      acc = bus_a.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL accept_timeout: observed no in_ready expected accept");
    end
  endtask

  task automatic send_frame_a(input logic [6:0] msg, input bit gaps);
    for (int i = 6; i >= 0; i--) drive_beat_a(msg[i], gaps);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [6:0] msg;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 5'b0;
    bus_b.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus_a.out_data), 32'd0);
    chk("rst_sof_eof", 32'({bus_a.out_sof, bus_a.out_eof}), 32'd0);
    chk("rst_state", 32'(st_a), 32'(MSG));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-1 message at the top: 15 back-to-back beats.
    push_frame(7'b1000000, 8'b11101000);
    send_frame_a(7'b1000000, 1'b0);
    wait_drain(100);
    chk("t1_run_len", 32'(last_eof_cyc - last_sof_cyc), 32'd14);

    // Lowest message bit: parity equals the generator's low bits.
    push_frame(7'b0000001, 8'b11010001);
    send_frame_a(7'b0000001, 1'b0);
    wait_drain(100);

    // Wide instance, BCH(15,5), one data beat and two parity beats.
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 5'b00001;
    @(negedge clk);
    chk("b_in_ready_msg", 32'(bus_b.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    chk("b_beat0", 32'({bus_b.out_valid, bus_b.out_sof, bus_b.out_eof, bus_b.out_data}),
        32'({3'b110, 5'b00001}));
    chk("b_in_ready_par0", 32'(bus_b.in_ready), 32'd0);
    @(negedge clk);
    chk("b_beat1", 32'({bus_b.out_valid, bus_b.out_sof, bus_b.out_eof, bus_b.out_data}),
        32'({3'b100, 5'b01001}));
    chk("b_in_ready_par1", 32'(bus_b.in_ready), 32'd0);
    @(negedge clk);
    chk("b_beat2", 32'({bus_b.out_valid, bus_b.out_sof, bus_b.out_eof, bus_b.out_data}),
        32'({3'b101, 5'b10111}));
    chk("b_state_back", 32'(st_b), 32'(MSG));
    @(negedge clk);
    chk("b_drained", 32'(bus_b.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Random frames under random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      msg = 7'($urandom_range(0, 127));
      push_frame(msg, ref_par(msg));
      send_frame_a(msg, 1'b1);
    end
    rand_ready = 1'b0;
    wait_drain(2000);

    // Nonzero frame followed immediately by an all-zero frame.
    push_frame(7'b1111111, ref_par(7'b1111111));
    push_frame(7'b0000000, 8'b00000000);
    send_frame_a(7'b1111111, 1'b0);
    send_frame_a(7'b0000000, 1'b0);
    wait_drain(100);

    // Reset after three message beats discards the partial codeword.
    push_frame(7'b1011001, ref_par(7'b1011001));
    drive_beat_a(1'b1, 1'b0);
    drive_beat_a(1'b0, 1'b0);
    drive_beat_a(1'b1, 1'b0);
    bus_a.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("async_rst_state", 32'(st_a), 32'(MSG));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(7'b0000001, 8'b11010001);
    send_frame_a(7'b0000001, 1'b0);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_encode_par.md
Name: bch_encode_par

Overview:
- Parallel systematic BCH encoder; successor to the bit-serial bch_encode.
- Accepts WIDTH message bits per beat over a valid/ready stream and emits a full N-bit codeword stream: K message bits passed through, then N-K parity bits.
- Full backpressure on both sides, with frame-boundary flags on the output.
- Sits between the framer and the modulator-side FIFO.

Parameters:
- N, 15, codeword length in bits.
- K, 7, message length in bits.
- WIDTH, 1, bits per beat. Must divide both K and N-K; an elaboration-time $error fires otherwise.
- GEN_POLY, 9'b111010001, generator polynomial, N-K+1 bits, MSB is x^(N-K). Default is BCH(15,7), t=2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  message bits; MSB is the earliest (highest-degree) bit
- in_valid  in  1  in_data valid
- in_ready  out  1  encoder accepts in_data this cycle
- out_data  out  WIDTH  codeword bits, MSB earliest
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_sof  out  1  first beat of codeword (qualified by out_valid)
- out_eof  out  1  last parity beat of codeword (qualified by out_valid)

Behaviour:
- One clock domain. rst_n is asynchronous assert, active-low.
- Reset values:
  - state=MSG; beat counter=0; parity register (N-K bits)=0
  - out_valid=0, out_data=0, out_sof=0, out_eof=0
  - in_ready is combinational, so it reads 1 after reset.
- Constants: DB=K/WIDTH data beats; PB=(N-K)/WIDTH parity beats.
- Output register is a single stage. adv = !out_valid || out_ready.
- State MSG:
  - in_ready = adv.
  - On in_valid && in_ready:
    - out_data <= in_data; out_valid <= 1; out_sof <= (cnt==0).
    - Parity register advances WIDTH LFSR steps in one cycle (unrolled, MSB bit first). Per step: fb = msg_bit ^ par[N-K-1]; par = (par<<1) ^ (fb ? GEN_POLY[N-K-1:0] : 0).
    - cnt++. On cnt==DB-1: cnt <= 0 and go to PAR.
- State PAR:
  - in_ready = 0.
  - When adv: out_data <= par[N-K-1 -: WIDTH]; par <<= WIDTH with zero fill; out_valid <= 1; out_sof <= 0; cnt++.
  - On cnt==PB-1: out_eof <= 1, par <= 0, cnt <= 0, go to MSG.
- Output hold and drain:
  - If adv and no new beat is loaded: out_valid <= 0, out_sof <= 0, out_eof <= 0.
  - While out_valid && !out_ready, all output registers hold and the state does not advance.
- Throughput and latency:
  - Full throughput: one beat per cycle with out_ready held high.
  - Codeword takes N/WIDTH beats; the next frame's first data beat is accepted the cycle after the last parity beat is loaded.
  - Latency from in accept to out_data is 1 cycle.
- Stalls: in_valid low mid-message stalls without corrupting parity; output bubbles are allowed.
- Simultaneous out_ready && load: the old beat is consumed and the new beat is loaded in the same edge.
- Reset mid-frame: the partial codeword is discarded, the registers above return to reset values, and the next accepted beat starts a new frame (out_sof=1).
- Parity is linear: an all-zero message yields all-zero parity.

Decomposition:
- Package bch_pkg: state enum (MSG, PAR); function for the one-step LFSR update; BCH(15,7) and BCH(15,5) generator-polynomial localparams.
- Sub-module bch_lfsr_step: combinational WIDTH-step parity update, parameterised by N-K, WIDTH and GEN_POLY; reused by a future decoder syndrome block.

Test Plan:
- Defaults, message 1000000 serial with out_ready=1 -> codeword 100000011101000; out_sof on beat 0, out_eof on beat 14; 15 consecutive valid beats.
- Defaults, message 0000001 -> codeword 000000111010001 (equal to GEN_POLY).
- N=15, K=5, WIDTH=5, GEN_POLY=11'b10100110111, in 00001 -> three beats 00001, 01001, 10111; eof on the third beat; in_ready=0 during the two parity beats.
- Random out_ready toggling (50%) and in_valid gaps over 200 back-to-back random frames -> every codeword matches the software reference encoder; no beat is lost or duplicated; out_data is stable while stalled.
- rst_n pulsed low for 2 cycles after 3 message beats -> out_valid=0 immediately (async); the next frame encodes 0000001 correctly with out_sof=1.
- All-zero message back-to-back with the previous nonzero frame -> parity all zeros, proving par clears at frame end.
